// File: rtl/dct_1d_row_loader_pkg.sv
// rtl/dct_1d_row_loader_pkg.sv - shared DCT constants and lane-pairing helpers
package dct_1d_row_loader_pkg;

    localparam int DCT_WIDTH     = 8;
    localparam int DCT_LANES     = 8;
    localparam int DCT_ROW_STORE = DCT_LANES - 1;

    function automatic int level_shift_const(input int width);
        return 1 << (width - 1);
    endfunction

    // Butterfly partner of a lane: lane k pairs with lane 7-k.
    function automatic int lane_pair(input int lane);
        return DCT_LANES - 1 - lane;
    endfunction

endpackage

// File: rtl/dct_1d_butterfly_1.sv
// rtl/dct_1d_butterfly_1.sv - first DCT butterfly stage, combinational sums and differences
module dct_1d_butterfly_1
    import dct_1d_row_loader_pkg::*;
#(
    parameter int WIDTH = DCT_WIDTH
) (
    input  logic signed [WIDTH-1:0] lane_in  [DCT_LANES],
    output logic signed [WIDTH:0]   lane_out [DCT_LANES]
);

    logic signed [WIDTH:0] ext [DCT_LANES];

    genvar k;
    generate
        for (k = 0; k < DCT_LANES; k++) begin : g_ext
            assign ext[k] = (WIDTH+1)'(lane_in[k]);
        end
        // Sums fill the low half, differences the high half in mirrored order.
        for (k = 0; k < DCT_LANES / 2; k++) begin : g_bfly
            assign lane_out[k]            = ext[k] + ext[lane_pair(k)];
            assign lane_out[lane_pair(k)] = ext[k] - ext[lane_pair(k)];
        end
    endgenerate

endmodule

// File: rtl/dct_1d_row_loader.sv
// rtl/dct_1d_row_loader.sv - level-shifts serial pixels, gathers rows, registers butterfly-1 lanes
module dct_1d_row_loader
    import dct_1d_row_loader_pkg::*;
#(
    parameter int WIDTH = DCT_WIDTH
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic                    In_Valid,
    input  logic [WIDTH-1:0]        In_Pixel,
    input  logic                    In_Sync,
    output logic                    Out_Valid,
    output logic signed [WIDTH:0]   Out_Data_0,
    output logic signed [WIDTH:0]   Out_Data_1,
    output logic signed [WIDTH:0]   Out_Data_2,
    output logic signed [WIDTH:0]   Out_Data_3,
    output logic signed [WIDTH:0]   Out_Data_4,
    output logic signed [WIDTH:0]   Out_Data_5,
    output logic signed [WIDTH:0]   Out_Data_6,
    output logic signed [WIDTH:0]   Out_Data_7,
    output logic [2:0]              Out_Row,
    output logic                    Out_Block_End
);

    localparam logic [WIDTH-1:0] LEVEL_SHIFT = WIDTH'(level_shift_const(WIDTH));

    logic [2:0]              col;
    logic [2:0]              row;
    logic signed [WIDTH-1:0] row_reg [DCT_ROW_STORE];
    logic signed [WIDTH-1:0] pixel_shifted;
    logic signed [WIDTH-1:0] bf_in  [DCT_LANES];
    logic signed [WIDTH:0]   bf_out [DCT_LANES];

    assign pixel_shifted = signed'(In_Pixel - LEVEL_SHIFT);

    // The eighth pixel feeds the butterfly directly instead of being stored.
    genvar j;
    generate
        for (j = 0; j < DCT_ROW_STORE; j++) begin : g_bf_in
            assign bf_in[j] = row_reg[j];
        end
    endgenerate
    assign bf_in[DCT_LANES-1] = pixel_shifted;

    dct_1d_butterfly_1 #(
        .WIDTH (WIDTH)
    ) u_butterfly (
        .lane_in  (bf_in),
        .lane_out (bf_out)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            col           <= 3'd0;
            row           <= 3'd0;
            Out_Valid     <= 1'b0;
            Out_Row       <= 3'd0;
            Out_Block_End <= 1'b0;
            Out_Data_0    <= '0;
            Out_Data_1    <= '0;
            Out_Data_2    <= '0;
            Out_Data_3    <= '0;
            Out_Data_4    <= '0;
            Out_Data_5    <= '0;
            Out_Data_6    <= '0;
            Out_Data_7    <= '0;
            for (int i = 0; i < DCT_ROW_STORE; i++) begin
                row_reg[i] <= '0;
            end
        end else begin
            Out_Valid <= 1'b0;
            if (In_Valid) begin
                if (In_Sync) begin
                    // Sync restarts the block; a pending partial row is dropped.
                    row_reg[0] <= pixel_shifted;
                    col        <= 3'd1;
                    row        <= 3'd0;
                end else if (col == 3'd7) begin
                    Out_Data_0    <= bf_out[0];
                    Out_Data_1    <= bf_out[1];
                    Out_Data_2    <= bf_out[2];
                    Out_Data_3    <= bf_out[3];
                    Out_Data_4    <= bf_out[4];
                    Out_Data_5    <= bf_out[5];
                    Out_Data_6    <= bf_out[6];
                    Out_Data_7    <= bf_out[7];
                    Out_Row       <= row;
                    Out_Block_End <= (row == 3'd7);
                    Out_Valid     <= 1'b1;
                    col           <= 3'd0;
                    row           <= row + 3'd1;
                end else begin
                    for (int i = 0; i < DCT_ROW_STORE; i++) begin
                        if (col == 3'(i)) begin
                            row_reg[i] <= pixel_shifted;
                        end
                    end
                    col <= col + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dct_1d_row_loader.sv
// tb/tb_dct_1d_row_loader.sv - directed self-checking bench for dct_1d_row_loader
module tb_dct_1d_row_loader;

    logic              Clock;
    logic              Reset_n;
    logic              In_Valid;
    logic [7:0]        In_Pixel;
    logic              In_Sync;
    logic              Out_Valid;
    logic signed [8:0] od0, od1, od2, od3, od4, od5, od6, od7;
    logic [2:0]        Out_Row;
    logic              Out_Block_End;

    int checks = 0;
    int errors = 0;

    dct_1d_row_loader #(.WIDTH(8)) dut (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .In_Valid      (In_Valid),
        .In_Pixel      (In_Pixel),
        .In_Sync       (In_Sync),
        .Out_Valid     (Out_Valid),
        .Out_Data_0    (od0),
        .Out_Data_1    (od1),
        .Out_Data_2    (od2),
        .Out_Data_3    (od3),
        .Out_Data_4    (od4),
        .Out_Data_5    (od5),
        .Out_Data_6    (od6),
        .Out_Data_7    (od7),
        .Out_Row       (Out_Row),
        .Out_Block_End (Out_Block_End)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_value(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic send_pixel(input logic [7:0] p, input logic sync);
        @(negedge Clock);
        In_Valid = 1'b1;
        In_Pixel = p;
        In_Sync  = sync;
        @(posedge Clock);
        #1;
        In_Valid = 1'b0;
        In_Sync  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic send_row(input string tag, input logic [7:0] px [8], input logic sync_first, input int gap);
        for (int i = 0; i < 8; i++) begin
            send_pixel(px[i], sync_first && (i == 0));
            check_value($sformatf("%s_valid_px%0d", tag, i), int'(Out_Valid), (i == 7) ? 1 : 0);
            for (int g = 0; g < gap; g++) begin
                idle_cycle();
                check_value($sformatf("%s_valid_gap%0d_%0d", tag, i, g), int'(Out_Valid), 0);
            end
        end
    endtask

    task automatic check_row(input string tag, input int exp_data [8], input int exp_row, input int exp_end);
        int got [8];
        got = '{int'(od0), int'(od1), int'(od2), int'(od3), int'(od4), int'(od5), int'(od6), int'(od7)};
        for (int k = 0; k < 8; k++) begin
            check_value($sformatf("%s_lane%0d", tag, k), got[k], exp_data[k]);
        end
        check_value($sformatf("%s_row", tag), int'(Out_Row), exp_row);
        check_value($sformatf("%s_end", tag), int'(Out_Block_End), exp_end);
    endtask

    logic [7:0] px_mid  [8] = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
    logic [7:0] px_ramp [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    logic [7:0] px_max  [8] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    logic [7:0] px_min  [8] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] px_edge [8] = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

    int exp_zero [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int exp_ramp [8] = '{-249, -249, -249, -249, -1, -3, -5, -7};
    int exp_max  [8] = '{254, 254, 254, 254, 0, 0, 0, 0};
    int exp_min  [8] = '{-256, -256, -256, -256, 0, 0, 0, 0};
    int exp_edge [8] = '{-1, -256, -256, -256, 0, 0, 0, 255};

    initial begin
        Reset_n  = 1'b0;
        In_Valid = 1'b0;
        In_Pixel = 8'd0;
        In_Sync  = 1'b0;
        idle_cycle();
        idle_cycle();
        check_value("reset_valid", int'(Out_Valid), 0);
        check_row("reset", exp_zero, 0, 0);
        @(negedge Clock);
        Reset_n = 1'b1;

        for (int r = 0; r < 8; r++) begin
            send_row($sformatf("mid_r%0d", r), px_mid, r == 0, 0);
            check_row($sformatf("mid_r%0d", r), exp_zero, r, (r == 7) ? 1 : 0);
        end
        idle_cycle();
        check_value("mid_pulse_once", int'(Out_Valid), 0);

        send_row("ramp", px_ramp, 1'b0, 0);
        check_row("ramp", exp_ramp, 0, 0);
        send_row("max", px_max, 1'b0, 0);
        check_row("max", exp_max, 1, 0);
        send_row("min", px_min, 1'b0, 0);
        check_row("min", exp_min, 2, 0);
        send_row("edge", px_edge, 1'b0, 0);
        check_row("edge", exp_edge, 3, 0);

        send_row("gap", px_ramp, 1'b0, 1);
        check_row("gap", exp_ramp, 4, 0);

        for (int i = 0; i < 4; i++) begin
            send_pixel(8'd255, 1'b0);
            check_value($sformatf("partial_valid_px%0d", i), int'(Out_Valid), 0);
        end
        send_row("sync", px_max, 1'b1, 0);
        check_row("sync", exp_max, 0, 0);

        send_row("post_sync1", px_ramp, 1'b0, 0);
        check_row("post_sync1", exp_ramp, 1, 0);
        send_row("post_sync2", px_ramp, 1'b0, 0);
        check_row("post_sync2", exp_ramp, 2, 0);

        for (int i = 0; i < 4; i++) begin
            send_pixel(8'd255, 1'b0);
        end
        @(negedge Clock);
        Reset_n = 1'b0;
        #1;
        check_value("rst_mid_valid", int'(Out_Valid), 0);
        check_row("rst_mid", exp_zero, 0, 0);
        @(negedge Clock);
        Reset_n = 1'b1;

        send_row("after_rst", px_min, 1'b0, 0);
        check_row("after_rst", exp_min, 0, 0);
        idle_cycle();
        check_value("after_rst_pulse_once", int'(Out_Valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
